// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size encodings, latency FSM states and lane/extension helpers
// shared by the tinymips data memory.
package data_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {ST_IDLE, ST_WAIT} lat_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        return size == SZ_BYTE ? 4'b0001 << addr :
               size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
               size == SZ_WORD ? 4'hf : 4'h0;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*addr +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        return size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
               size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    endfunction
endpackage

// File: rtl/data_mem_ram_be.sv
// ram_be: four-lane byte-enable word storage with synchronous write and
// registered read.
module ram_be #(
    parameter int DEPTH     = 4096,
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wd_i,
    input  logic                 re_i,
    output logic [31:0]          rd_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++)
            if (we_i && be_i[k]) mem_q[addr_i][8*k +: 8] <= wd_i[8*k +: 8];
        if (re_i) rd_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressed MIPS load/store memory with legality checks,
// configurable read latency and a valid-flagged, extended read result.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_DEPTH = 4096,
    parameter int RD_LATENCY = 1,
    parameter int DLY        = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [1:0]            SIZE,
    input  logic                  SIGNED,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [31:0]           WD,
    output logic                  BUSY,
    output logic [31:0]           RD,
    output logic                  RVALID,
    output logic                  ERR
);
    localparam int AB = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;

    if (RD_LATENCY < 1 || RD_LATENCY > 4 || DATA_DEPTH < 1 || DLY < 0) begin : g_bad_param
        $error("data_mem: illegal parameter value");
    end

    lat_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d, lsize_q, lane_q;
    logic        rvalid_q, rvalid_d, serr_q, lerr_q, lsgn_q;
    logic        acc, illegal;
    logic [31:0] rd_q, ram_rd, wdata;

    assign acc     = REQ & ~BUSY;
    assign illegal = SIZE == SZ_RSVD || (SIZE == SZ_HALF && A[0]) ||
                     (SIZE == SZ_WORD && A[1:0] != 2'b00) ||
                     64'(A[ADDR_WIDTH-1:2]) >= 64'(DATA_DEPTH);
    // Replicate store data so every enabled lane sees its own slice.
    assign wdata   = SIZE == SZ_BYTE ? {4{WD[7:0]}} : SIZE == SZ_HALF ? {2{WD[15:0]}} : WD;

    ram_be #(.DEPTH(DATA_DEPTH), .ADDR_BITS(AB)) u_ram (
        .clk_i  (CLK),
        .we_i   (acc & WE & ~illegal),
        .be_i   (lane_mask(SIZE, A[1:0])),
        .addr_i (A[AB+1:2]),
        .wd_i   (wdata),
        .re_i   (acc & ~WE & ~illegal),
        .rd_o   (ram_rd)
    );

    assign BUSY   = state_q == ST_WAIT;
    assign RVALID = rvalid_q;
    assign ERR    = serr_q | (rvalid_q & lerr_q);
    assign RD     = rvalid_q ? (lerr_q ? 32'd0 : load_extend(ram_rd, lsize_q, lane_q, lsgn_q)) : rd_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (acc && !WE) begin
                if (RD_LATENCY == 1) rvalid_d = 1'b1;
                else begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'(RD_LATENCY - 1);
                end
            end
        end else begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            rvalid_q <= 1'b0;
            serr_q   <= 1'b0;
            lerr_q   <= 1'b0;
            lsize_q  <= SZ_BYTE;
            lane_q   <= 2'd0;
            lsgn_q   <= 1'b0;
            rd_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            serr_q   <= acc & WE & illegal;
            rd_q     <= RD;
            if (acc && !WE) begin
                lerr_q  <= illegal;
                lsize_q <= SIZE;
                lane_q  <= A[1:0];
                lsgn_q  <= SIGNED;
            end
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed checks of data_mem at read latency 1 and 3.
module tb_data_mem;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req1 = 1'b0, req3 = 1'b0, we = 1'b0, sgn = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] a = '0, wd = '0;
    logic        busy1, rv1, err1, busy3, rv3, err3;
    logic [31:0] rd1, rd3;
    int          total = 0, bad = 0;

    data_mem #(.RD_LATENCY(1)) u1 (
        .CLK(clk), .RST(rst), .REQ(req1), .WE(we), .SIZE(size), .SIGNED(sgn),
        .A(a), .WD(wd), .BUSY(busy1), .RD(rd1), .RVALID(rv1), .ERR(err1)
    );
    data_mem #(.RD_LATENCY(3)) u3 (
        .CLK(clk), .RST(rst), .REQ(req3), .WE(we), .SIZE(size), .SIGNED(sgn),
        .A(a), .WD(wd), .BUSY(busy3), .RD(rd3), .RVALID(rv3), .ERR(err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge, returning in the following cycle.
    task automatic go(input logic w, input logic [1:0] s, input logic g,
                      input logic [31:0] ad, input logic [31:0] d, input bit on3);
        we = w; size = s; sgn = g; a = ad; wd = d;
        if (on3) req3 = 1'b1; else req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_rvalid", 32'(rv1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_rd", rd1, 0);
        @(negedge clk) rst = 1'b0;

        go(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        chk("sw_err", 32'(err1), 0);
        chk("sw_rvalid", 32'(rv1), 0);
        go(0, 2'b10, 0, 32'h10, 0, 0);
        chk("lw_rvalid", 32'(rv1), 1);
        chk("lw_rd", rd1, 32'hDEADBEEF);
        chk("lw_err", 32'(err1), 0);
        chk("lw_busy", 32'(busy1), 0);
        @(negedge clk);
        chk("lw_rvalid_drop", 32'(rv1), 0);
        chk("rd_hold", rd1, 32'hDEADBEEF);

        go(1, 2'b00, 0, 32'h11, 32'h000000A5, 0);
        go(0, 2'b10, 0, 32'h10, 0, 0);
        chk("sb_lw", rd1, 32'hDEADA5EF);
        go(0, 2'b00, 1, 32'h11, 0, 0);
        chk("lb", rd1, 32'hFFFFFFA5);
        go(0, 2'b00, 0, 32'h11, 0, 0);
        chk("lbu", rd1, 32'h000000A5);

        go(1, 2'b01, 0, 32'h12, 32'h00008001, 0);
        go(0, 2'b01, 1, 32'h12, 0, 0);
        chk("lh", rd1, 32'hFFFF8001);
        go(0, 2'b01, 0, 32'h12, 0, 0);
        chk("lhu", rd1, 32'h00008001);

        go(1, 2'b10, 0, 32'h13, 32'h11111111, 0);
        chk("sw_mis_err", 32'(err1), 1);
        chk("sw_mis_rvalid", 32'(rv1), 0);
        @(negedge clk);
        chk("sw_mis_err_pulse", 32'(err1), 0);
        go(0, 2'b10, 0, 32'h10, 0, 0);
        chk("sw_mis_nowrite", rd1, 32'h8001A5EF);

        go(0, 2'b01, 1, 32'h11, 0, 0);
        chk("lh_mis_rvalid", 32'(rv1), 1);
        chk("lh_mis_err", 32'(err1), 1);
        chk("lh_mis_rd", rd1, 0);
        go(0, 2'b10, 0, 32'h4000, 0, 0);
        chk("lw_oor_err", 32'(err1), 1);
        chk("lw_oor_rvalid", 32'(rv1), 1);
        go(0, 2'b11, 0, 32'h10, 0, 0);
        chk("rsvd_err", 32'(err1), 1);
        chk("rsvd_rd", rd1, 0);

        go(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 1);
        go(1, 2'b10, 0, 32'h24, 32'h12345678, 1);
        we = 0; size = 2'b10; a = 32'h20; req3 = 1'b1;
        @(negedge clk);
        chk("l3_busy_t1", 32'(busy3), 1);
        chk("l3_rv_t1", 32'(rv3), 0);
        @(negedge clk);
        chk("l3_busy_t2", 32'(busy3), 1);
        @(negedge clk);
        chk("l3_rv_t3", 32'(rv3), 1);
        chk("l3_rd_t3", rd3, 32'hCAFEF00D);
        chk("l3_busy_t3", 32'(busy3), 0);
        a = 32'h24;
        @(negedge clk);
        req3 = 1'b0;
        chk("l3_b2b_busy_t4", 32'(busy3), 1);
        chk("l3_b2b_rv_t4", 32'(rv3), 0);
        chk("l3_rd_hold_t4", rd3, 32'hCAFEF00D);
        @(negedge clk);
        chk("l3_b2b_rv_t5", 32'(rv3), 0);
        @(negedge clk);
        chk("l3_b2b_rv_t6", 32'(rv3), 1);
        chk("l3_b2b_rd_t6", rd3, 32'h12345678);

        go(0, 2'b10, 0, 32'h20, 0, 1);
        chk("abort_busy", 32'(busy3), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy_rst", 32'(busy3), 0);
        chk("abort_rv_rst", 32'(rv3), 0);
        chk("abort_err_rst", 32'(err3), 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_rv", 32'(rv3), 0);
            @(negedge clk);
        end
        go(0, 2'b10, 0, 32'h20, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("keep_rv", 32'(rv3), 1);
        chk("keep_rd", rd3, 32'hCAFEF00D);
        go(0, 2'b10, 0, 32'h10, 0, 0);
        chk("keep_rd_u1", rd1, 32'h8001A5EF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Next-generation data memory for the tinymips core. Replaces the flat word RAM.
- Accepts byte-addressed MIPS load/store requests: LB/LBU/LH/LHU/LW and SB/SH/SW.
- Applies byte-lane write enables and sign/zero extension on loads.
- Read latency is configurable and read data comes back through a valid flag. Misaligned, out-of-range and reserved-size accesses are flagged.

Parameters:
- ADDR_WIDTH, 32, width of the byte address A.
- DATA_DEPTH, 4096, number of 32-bit words stored. Any positive value; need not be a power of two.
- RD_LATENCY, 1, cycles from read acceptance to RVALID. Legal range 1..4; elaboration error outside it.
- DLY, 1, simulation-only delay on registered storage writes.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  1  request strobe; sampled only when BUSY=0.
- WE  input  1  1 = store, 0 = load.
- SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved.
- SIGNED  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- A  input  ADDR_WIDTH  byte address.
- WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- BUSY  output  1  1 = request not accepted this cycle.
- RD  output  32  load result, extended to 32 bits.
- RVALID  output  1  one-cycle pulse: RD is valid.
- ERR  output  1  one-cycle pulse: the completing access was illegal.

Behaviour:
- Reset (asynchronous): BUSY=0, RVALID=0, ERR=0, RD=0, latency counter and pipeline cleared. Storage contents are not reset.
- Acceptance: a request is accepted at edge T when REQ=1 and BUSY=0.
- Endianness: little-endian; byte lane k = bits [8k+7:8k]. Word index = A[ADDR_WIDTH-1:2].
- Illegal access, any of:
  - SIZE=11;
  - SIZE=01 with A[0]=1;
  - SIZE=10 with A[1:0]!=00;
  - word index >= DATA_DEPTH.
- Store, legal:
  - Storage updated at edge T; BUSY stays 0.
  - Byte: WD[7:0] written to lane A[1:0].
  - Half: WD[15:0] written to lanes {A[1],1} and {A[1],0}.
  - Word: all four lanes written.
  - Other lanes unchanged.
  - ERR=0, RVALID=0.
- Store, illegal: no lanes written; ERR=1 during cycle T+1 only; RVALID=0.
- Load:
  - RVALID=1 for exactly cycle T+RD_LATENCY.
  - BUSY=1 for cycles T+1 .. T+RD_LATENCY-1, so it is never asserted when RD_LATENCY=1.
  - A request in cycle T+RD_LATENCY is accepted, back-to-back.
  - Legal: RD = selected lane(s) extended per SIGNED (byte lane A[1:0]; half lanes {A[1],1},{A[1],0}; word unmodified); ERR=0.
  - Illegal: RD=0 and ERR=1, both in the RVALID cycle.
- RD holds its last value when RVALID=0.
- Read-after-write: a load accepted at T+1 after a store at T returns the new data. Storage is a registered-read array with write-first ordering for this case.
- Single outstanding access: one port, so no simultaneous read and write. REQ while BUSY=1 is ignored, neither queued nor flagged.
- Latency control: internal counter FSM.
  - IDLE to WAIT on read acceptance with RD_LATENCY>1; count loaded with RD_LATENCY-1.
  - WAIT decrements each cycle; returns to IDLE when the count reaches 1, which is the cycle before RVALID.
  - Load size, sign flag, lane select and error flag are captured at acceptance and travel with the request.
- Reset mid-read aborts the load: no RVALID or ERR pulse afterwards.

Decomposition:
- Package data_mem_pkg:
  - SIZE encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - function lane_mask(size, addr[1:0]) returning a 4-bit byte enable;
  - function load_extend(word, size, addr[1:0], signed) returning 32 bits.
- Sub-module ram_be:
  - parameters DEPTH and ADDR_BITS;
  - 4-lane byte-enable storage, synchronous write, registered read;
  - instantiated once.
- data_mem holds the handshake/latency FSM, legality checks and result pipeline.

Test Plan:
- SW A=0x10 WD=0xDEADBEEF, then LW A=0x10, RD_LATENCY=1 -> RVALID at T+1, RD=0xDEADBEEF, ERR=0, BUSY never high.
- SB A=0x11 WD=0x000000A5 onto 0xDEADBEEF, then LW -> RD=0xDEADA5EF; LB A=0x11 SIGNED=1 -> 0xFFFFFFA5; SIGNED=0 -> 0x000000A5.
- SH A=0x12 WD=0x8001, then LH A=0x12 SIGNED=1 -> RD=0xFFFF8001; LHU -> 0x00008001.
- RD_LATENCY=3, LW at T with REQ held high -> BUSY=1 at T+1,T+2; RVALID at T+3; second LW accepted at T+3, its RVALID at T+6.
- SW A=0x13 -> ERR pulse at T+1 and word 0x10 unchanged. LH A=0x11 -> RVALID with ERR=1, RD=0. LW A=4*DATA_DEPTH -> ERR=1. SIZE=11 -> ERR=1.
- RD_LATENCY=3, LW at T, RST pulsed at T+1 -> BUSY, RVALID, ERR all 0 immediately; no RVALID at T+3; storage contents preserved.
